muldiv_unit: RTL
================

Name: muldiv_unit

Overview:
- Iterative RV32M/RV64M multiply/divide execution unit, parametrised in XLEN.
- Sits beside the ALU in the EX stage and accepts one operation at a time.
- Raises busy so the hazard unit stalls IF/ID/EX until done.
- Results are returned with the destination register tag for forwarding into EX/MEM.

Parameters:
- XLEN, 32, operand/result width; legal values are 32 and 64.
- TAG_W, 5, width of the destination register tag carried through the unit.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous reset, active-high.
- start  in  1  request; sampled only when busy=0.
- op  in  3  funct3: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU.
- a  in  XLEN  rs1 operand (dividend / multiplicand).
- b  in  XLEN  rs2 operand (divisor / multiplier).
- rd_in  in  TAG_W  destination tag.
- flush  in  1  abort the current operation (branch/jal redirect).
- busy  out  1  high whenever state != IDLE.
- done  out  1  one-cycle pulse; result is valid in that cycle.
- result  out  XLEN  result; held until the next done.
- rd_out  out  TAG_W  tag of result; held with result.

Behaviour:
- Reset (synchronous, rst=1 at edge): state=IDLE, busy=0, done=0, result=0, rd_out=0, all internal registers=0.
- States:
  - IDLE -> PREP on start && !flush && !fast_case.
  - PREP (1 cycle): latch |a|, |b|, result sign, op, rd_in; clear accumulator and counter.
  - CALC (XLEN cycles): one bit per cycle.
    - Multiply: shift-add, multiplier |b| LSB first, multiplicand shifted left in a 2*XLEN register.
    - Divide: restoring, one quotient bit per cycle, MSB first.
    - Counter runs 0..XLEN-1; at XLEN-1 -> FIX.
  - FIX (1 cycle): apply sign correction, select result, -> IDLE with done=1 registered.
- Sign rules:
  - MULH: both operands signed. MULHSU: a signed, b unsigned. MULHU/DIVU/REMU: unsigned.
  - Product sign = sign(a) xor sign(b) for signed operands.
  - Remainder sign = sign(a).
  - Quotient sign = sign(a) xor sign(b).
- Result select:
  - MUL: low XLEN of the 2*XLEN product.
  - MULH/MULHSU/MULHU: high XLEN of the product.
  - DIV/DIVU: quotient. REM/REMU: remainder.
- Latency: start sampled in cycle 0 -> PREP cycle 1, CALC cycles 2..XLEN+1, FIX cycle XLEN+2, done=1 in cycle XLEN+3 (35 for XLEN=32).
- Fast cases, resolved in IDLE, no PREP/CALC; done=1 in cycle 1, busy never asserted:
  - Divide by zero: DIV/DIVU quotient = all ones; REM/REMU = a.
  - Signed overflow (a = most negative, b = -1): DIV = a; REM = 0.
- Back-to-back: start is accepted in the same cycle done=1 (state is IDLE).
- start while busy=1: ignored; no queuing.
- flush:
  - In any state: next state IDLE, done=0, result/rd_out unchanged.
  - flush together with start in IDLE: start dropped.
  - flush together with the FIX cycle: done suppressed.
- rst mid-operation: same as reset; no done pulse.
- Arithmetic: all internal widths are XLEN or 2*XLEN, with no truncation before FIX. The divider subtract is XLEN+1 bits wide to capture the borrow.

Optional Feature:
- MULDIV_EARLY_OUT_EN, multiply ops only (op 0..3).
- Defined:
  - After each CALC iteration, if the remaining shifted multiplier is zero, go to FIX next cycle.
  - Latency varies: done in cycle 4 + (index of the MSB set in |b|); |b|=0 gives done in cycle 4.
  - Divide latency is unchanged.
- Undefined: fixed latency XLEN+3 for all non-fast operations.

Test Plan:
- MUL a=7, b=0xFFFFFFF9 (-7) -> result 0xFFFFFFCF, rd_out=rd_in, done only in cycle 35, busy high in cycles 1..34.
- MULH a=b=0x80000000 -> 0x40000000; MULHU 0xFFFFFFFF*0xFFFFFFFF -> 0xFFFFFFFE; MULHSU a=0xFFFFFFFF, b=2 -> 0xFFFFFFFF.
- DIV a=-7, b=2 -> 0xFFFFFFFD; REM same operands -> 0xFFFFFFFF; DIVU 100/7 -> 14; REMU 100/7 -> 2.
- DIVU 5/0 -> 0xFFFFFFFF and REM 5/0 -> 5, both with done in cycle 1 and busy=0 throughout; DIV 0x80000000/0xFFFFFFFF -> 0x80000000 and REM -> 0, also in cycle 1.
- Flush and reset interrupting operations:
  - start DIV, flush in cycle 10 -> busy=0 in cycle 11, no done, result unchanged; new MUL started in cycle 11 -> done in cycle 46.
  - rst in cycle 20 of an operation -> all outputs 0 next cycle, no done.
- Back-to-back and early-out:
  - second start in the done cycle -> accepted, next done 35 cycles later.
  - with MULDIV_EARLY_OUT_EN: MUL 5*3 -> result 15, done in cycle 5.

Source files
------------

// File: rtl/muldiv_unit.sv
// Iterative RV32M/RV64M multiply/divide unit: shift-add multiply, restoring divide.
// Optional MULDIV_EARLY_OUT_EN ends a multiply as soon as the remaining multiplier is zero.
module muldiv_unit #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [XLEN-1:0]  a,
  input  logic [XLEN-1:0]  b,
  input  logic [TAG_W-1:0] rd_in,
  input  logic             flush,
  output logic             busy,
  output logic             done,
  output logic [XLEN-1:0]  result,
  output logic [TAG_W-1:0] rd_out
);
  localparam int CW = $clog2(XLEN);

  typedef enum logic [1:0] {IDLE, PREP, CALC, FIX} state_t;

  state_t              state_q, state_d;
  logic [2:0]          op_q, op_d;
  logic [TAG_W-1:0]    rd_q, rd_d, rd_out_q, rd_out_d;
  logic                neg_res_q, neg_res_d, neg_rem_q, neg_rem_d;
  logic [2*XLEN-1:0]   mcand_q, mcand_d, acc_q, acc_d;
  logic [XLEN-1:0]     mplier_q, mplier_d, result_q, result_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic                done_q, done_d;

  logic                a_signed, b_signed, neg_a, neg_b;
  logic [XLEN-1:0]     abs_a, abs_b, fast_result, quo_fix, rem_fix;
  logic                div_zero, div_ovf;
  logic [XLEN:0]       partial, trial;
  logic [2*XLEN-1:0]   prod_fix;

  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    rd_d      = rd_q;
    rd_out_d  = rd_out_q;
    neg_res_d = neg_res_q;
    neg_rem_d = neg_rem_q;
    mcand_d   = mcand_q;
    acc_d     = acc_q;
    mplier_d  = mplier_q;
    result_d  = result_q;
    cnt_d     = cnt_q;
    done_d    = 1'b0;

    a_signed = (op != 3'd3) && (op != 3'd5) && (op != 3'd7);
    b_signed = (op == 3'd0) || (op == 3'd1) || (op == 3'd4) || (op == 3'd6);
    neg_a    = a_signed && a[XLEN-1];
    neg_b    = b_signed && b[XLEN-1];
    abs_a    = neg_a ? (~a + 1'b1) : a;
    abs_b    = neg_b ? (~b + 1'b1) : b;

    div_zero = op[2] && (b == '0);
    div_ovf  = ((op == 3'd4) || (op == 3'd6)) &&
               (a == {1'b1, {(XLEN-1){1'b0}}}) && (b == '1);
    if (div_zero) fast_result = op[1] ? a : '1;
    else          fast_result = op[1] ? '0 : a;

    // Remainder-so-far with the next dividend bit appended; the extra top bit is the borrow
    partial  = acc_q[2*XLEN-1:XLEN-1];
    trial    = partial - {1'b0, mplier_q};

    prod_fix = neg_res_q ? (~acc_q + 1'b1) : acc_q;
    quo_fix  = neg_res_q ? (~acc_q[XLEN-1:0] + 1'b1) : acc_q[XLEN-1:0];
    rem_fix  = neg_rem_q ? (~acc_q[2*XLEN-1:XLEN] + 1'b1) : acc_q[2*XLEN-1:XLEN];

    case (state_q)
      IDLE: begin
        if (start) begin
          if (div_zero || div_ovf) begin
            result_d = fast_result;
            rd_out_d = rd_in;
            done_d   = 1'b1;
          end else begin
            state_d   = PREP;
            op_d      = op;
            rd_d      = rd_in;
            neg_res_d = neg_a ^ neg_b;
            neg_rem_d = neg_a;
            mcand_d   = {{XLEN{1'b0}}, abs_a};
            mplier_d  = abs_b;
          end
        end
      end
      PREP: begin
        acc_d   = op_q[2] ? {{XLEN{1'b0}}, mcand_q[XLEN-1:0]} : '0;
        cnt_d   = '0;
        state_d = CALC;
      end
      CALC: begin
        if (op_q[2]) begin
          acc_d = {(trial[XLEN] ? partial[XLEN-1:0] : trial[XLEN-1:0]),
                   acc_q[XLEN-2:0], ~trial[XLEN]};
        end else begin
          if (mplier_q[0]) acc_d = acc_q + mcand_q;
          mcand_d  = mcand_q << 1;
          mplier_d = mplier_q >> 1;
        end
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CW'(XLEN-1)) state_d = FIX;
`ifdef MULDIV_EARLY_OUT_EN
        else if (!op_q[2] && ((mplier_q >> 1) == '0)) state_d = FIX;
`endif
      end
      FIX: begin
        state_d  = IDLE;
        done_d   = 1'b1;
        rd_out_d = rd_q;
        case (op_q)
          3'd0:                result_d = prod_fix[XLEN-1:0];
          3'd1, 3'd2, 3'd3:    result_d = prod_fix[2*XLEN-1:XLEN];
          3'd4, 3'd5:          result_d = quo_fix;
          default:             result_d = rem_fix;
        endcase
      end
      default: state_d = IDLE;
    endcase

    // A redirect aborts whatever is in flight and keeps the last delivered result
    if (flush) begin
      state_d  = IDLE;
      done_d   = 1'b0;
      result_d = result_q;
      rd_out_d = rd_out_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      op_q      <= '0;
      rd_q      <= '0;
      rd_out_q  <= '0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      mcand_q   <= '0;
      acc_q     <= '0;
      mplier_q  <= '0;
      result_q  <= '0;
      cnt_q     <= '0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      rd_q      <= rd_d;
      rd_out_q  <= rd_out_d;
      neg_res_q <= neg_res_d;
      neg_rem_q <= neg_rem_d;
      mcand_q   <= mcand_d;
      acc_q     <= acc_d;
      mplier_q  <= mplier_d;
      result_q  <= result_d;
      cnt_q     <= cnt_d;
      done_q    <= done_d;
    end
  end

  assign busy   = (state_q != IDLE);
  assign done   = done_q;
  assign result = result_q;
  assign rd_out = rd_out_q;
endmodule
